dac_spi_rx: RTL and testbench
=============================

DAC_SPI_RX -- requirements
Module: dac_spi_rx

Interface
REQ-001 The block SHALL have the port clk_in, input, 1 bit: system clock, at least 4x the serial clock frequency; all logic on its rising edge.
REQ-002 The block SHALL have the port rst, input, 1 bit: reset, synchronous and active-low; rst = 0 sampled on a clk_in rising edge resets the block.
REQ-003 The block SHALL have the port sclk_in, input, 1 bit: serial clock from the DAC SPI master; asynchronous to clk_in.
REQ-004 The block SHALL have the port sync_in, input, 1 bit: frame strobe, active-low; a frame is the interval while it is low.
REQ-005 The block SHALL have the port din_in, input, 1 bit: serial data, MSB first; the master changes it on the falling edge of sclk_in.
REQ-006 The block SHALL have the port rx_word, output, 16 bits: last complete frame received.
REQ-007 The block SHALL have the port rx_code, output, 8 bits: equal to rx_word[7:0], the DAC voltage code.
REQ-008 The block SHALL have the port rx_valid, output, 1 bit: one-cycle pulse when rx_word updates.
REQ-009 The block SHALL have the port frame_err, output, 1 bit: one-cycle pulse on a short frame or an overrun frame.
REQ-010 The block SHALL have the port busy, output, 1 bit: high while the FSM is in SHIFT or DONE.
REQ-011 The block SHALL have the port frame_cnt, output, 16 bits: count of good frames.
REQ-012 The block SHALL have the port err_cnt, output, 8 bits: count of errored frames.

Function
REQ-013 The block SHALL pass sclk_in, sync_in and din_in each through a 2-flop synchronizer; sync_in synchronizer flops SHALL reset to 1, the others to 0.
REQ-014 The block SHALL detect a rising edge of sclk_in (sclk_r), a falling edge of sync_in (sync_f) and a rising edge of sync_in (sync_r) by comparing the synchronized value with one further delayed flop.
REQ-015 The block SHALL implement the FSM states IDLE, SHIFT and DONE, with IDLE as the reset state.
REQ-016 In IDLE, on sync_f, the block SHALL go to SHIFT and clear the bit counter (5 bits) to 0.
REQ-017 In SHIFT, on sclk_r, the block SHALL shift the synchronized din into the shift register LSB (left shift, MSB first) and increment the bit counter.
REQ-018 When the 16th bit shifts in, the block SHALL load rx_word from the shift register contents, pulse rx_valid on the next cycle, and go to DONE.
REQ-019 In SHIFT, on sync_r with bit counter < 16, the block SHALL pulse frame_err, leave rx_word unchanged, and go to IDLE.
REQ-020 If sclk_r and sync_r occur in the same cycle, the block SHALL process the bit first; if that bit is the 16th, the frame is good.
REQ-021 In DONE, on any sclk_r, the block SHALL set an internal overrun flag and SHALL NOT change the shift register or rx_word.
REQ-022 In DONE, on sync_r, the block SHALL go to IDLE and pulse frame_err if the overrun flag is set; the flag SHALL clear on leaving DONE.
REQ-023 If sync_in is low when rst releases, the block SHALL remain in IDLE until a genuine sync_f, with no partial-frame capture.
REQ-024 rx_code SHALL always equal rx_word[7:0] (combinational).
REQ-025 rx_valid and frame_err SHALL never both be high in the same cycle and SHALL never be high for two consecutive cycles for the same frame.
REQ-026 frame_cnt SHALL increment on each rx_valid and wrap from 0xFFFF to 0.
REQ-027 err_cnt SHALL increment on each frame_err and saturate at 0xFF.

Reset
REQ-028 When rst = 0 at a clk_in edge, the block SHALL return to IDLE and clear: rx_word = 0x0000, rx_valid = 0, frame_err = 0, busy = 0, frame_cnt = 0, err_cnt = 0, bit counter = 0, overrun flag = 0.
REQ-029 A reset mid-frame SHALL abort the frame with no rx_valid and no frame_err pulse.

Configuration
REQ-030 With macro DAC_SPI_RX_STATS_EN defined, the block SHALL implement frame_cnt and err_cnt as specified in REQ-026 and REQ-027.
REQ-031 Without DAC_SPI_RX_STATS_EN, the block SHALL omit the counters and tie frame_cnt and err_cnt to 0; the ports SHALL remain present.

Verification
REQ-032 The bench SHALL run a good frame: clk_in 50 MHz, sclk 10 MHz, 16 bits of 0x00A5 -> rx_word = 0x00A5, rx_code = 0xA5, one rx_valid pulse, frame_cnt = 1.
REQ-033 The bench SHALL run a short frame: sync rises after 10 bits -> one frame_err pulse, no rx_valid, rx_word holds its previous value, err_cnt += 1.
REQ-034 The bench SHALL run an overrun frame: 20 sclk edges with first 16 bits 0x00FF -> rx_valid with 0x00FF after bit 16, then frame_err at sync rise.
REQ-035 The bench SHALL run back-to-back frames 0x0012, 0x0034 and 0x0056, separated by a 1-sclk sync-high gap -> three rx_valid pulses in order, frame_cnt = 3.
REQ-036 The bench SHALL release rst while sync is low mid-frame, then run a full 0x0077 frame -> only 0x0077 is reported, and no error occurs.
REQ-037 The bench SHALL repeat REQ-032 to REQ-036 without DAC_SPI_RX_STATS_EN -> identical rx_word, rx_valid and frame_err behaviour, with frame_cnt = err_cnt = 0 throughout.

Source files
------------

// File: rtl/dac_spi_rx.sv
// dac_spi_rx: SPI slave receiver for 16-bit DAC frames, oversampled on clk_in.
// Define DAC_SPI_RX_STATS_EN to build the frame_cnt / err_cnt statistics counters.
//   state | meaning
//   IDLE  | waiting for a sync_in falling edge
//   SHIFT | frame open, shifting bits on sclk rising edges
//   DONE  | 16 bits captured, waiting for sync_in to rise
module dac_spi_rx (
    input  logic        clk_in,
    input  logic        rst,
    input  logic        sclk_in,
    input  logic        sync_in,
    input  logic        din_in,
    output logic [15:0] rx_word,
    output logic [7:0]  rx_code,
    output logic        rx_valid,
    output logic        frame_err,
    output logic        busy,
    output logic [15:0] frame_cnt,
    output logic [7:0]  err_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  sclk_pipe_q, sclk_pipe_d;
    logic [2:0]  sync_pipe_q, sync_pipe_d;
    logic [1:0]  din_pipe_q, din_pipe_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [15:0] shift_q, shift_d;
    logic [15:0] rx_word_q, rx_word_d;
    logic        rx_valid_q, rx_valid_d;
    logic        frame_err_q, frame_err_d;
    logic        overrun_q, overrun_d;
    logic        init_q, init_d;
    logic        armed_q, armed_d;

    logic        sclk_r, sync_f, sync_r, din_s, last_bit;
    logic [15:0] shift_next;

    assign sclk_r     = sclk_pipe_q[1] & ~sclk_pipe_q[2];
    assign sync_f     = ~sync_pipe_q[1] & sync_pipe_q[2];
    assign sync_r     = sync_pipe_q[1] & ~sync_pipe_q[2];
    assign din_s      = din_pipe_q[1];
    assign last_bit   = (bit_cnt_q == 5'd15);
    assign shift_next = {shift_q[14:0], din_s};

    always_comb begin
        sclk_pipe_d = {sclk_pipe_q[1:0], sclk_in};
        sync_pipe_d = {sync_pipe_q[1:0], sync_in};
        din_pipe_d  = {din_pipe_q[0], din_in};
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rx_word_d   = rx_word_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        overrun_d   = overrun_q;
        init_d      = 1'b1;
        // The sync synchronizer resets high, so its first real low sample looks
        // like a falling edge; only trust sync_f once sync_in has been seen high.
        armed_d     = armed_q | (init_q & sync_pipe_q[0]);

        case (state_q)
            IDLE: begin
                overrun_d = 1'b0;
                if (sync_f && armed_q) begin
                    state_d   = SHIFT;
                    bit_cnt_d = 5'd0;
                end
            end
            SHIFT: begin
                if (sclk_r) begin
                    shift_d   = shift_next;
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (last_bit) begin
                        rx_word_d  = shift_next;
                        rx_valid_d = 1'b1;
                        state_d    = sync_r ? IDLE : DONE;
                    end else if (sync_r) begin
                        frame_err_d = 1'b1;
                        state_d     = IDLE;
                    end
                end else if (sync_r) begin
                    frame_err_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            DONE: begin
                if (sclk_r) begin
                    overrun_d = 1'b1;
                end
                if (sync_r) begin
                    frame_err_d = overrun_q | sclk_r;
                    overrun_d   = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst) begin
            state_q     <= IDLE;
            sclk_pipe_q <= 3'b000;
            sync_pipe_q <= 3'b111;
            din_pipe_q  <= 2'b00;
            bit_cnt_q   <= 5'd0;
            shift_q     <= 16'h0000;
            rx_word_q   <= 16'h0000;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            init_q      <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            sclk_pipe_q <= sclk_pipe_d;
            sync_pipe_q <= sync_pipe_d;
            din_pipe_q  <= din_pipe_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rx_word_q   <= rx_word_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            init_q      <= init_d;
            armed_q     <= armed_d;
        end
    end

    assign rx_word   = rx_word_q;
    assign rx_code   = rx_word_q[7:0];
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q == SHIFT) || (state_q == DONE);

`ifdef DAC_SPI_RX_STATS_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [7:0]  err_cnt_q, err_cnt_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q + {15'd0, rx_valid_q};
        err_cnt_d   = err_cnt_q;
        if (frame_err_q && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst) begin
            frame_cnt_q <= 16'h0000;
            err_cnt_q   <= 8'h00;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign err_cnt   = err_cnt_q;
`else
    assign frame_cnt = 16'h0000;
    assign err_cnt   = 8'h00;
`endif

endmodule

// File: tb/tb_dac_spi_rx.sv
// Scoreboard bench for dac_spi_rx: clk_in 50 MHz, sclk 10 MHz, expected words queued per frame.
// Expected counter values follow DAC_SPI_RX_STATS_EN the same way the design does.
module tb_dac_spi_rx;

    logic        clk_in = 1'b0;
    logic        rst = 1'b0;
    logic        sclk_in = 1'b0;
    logic        sync_in = 1'b1;
    logic        din_in = 1'b0;
    logic [15:0] rx_word;
    logic [7:0]  rx_code;
    logic        rx_valid;
    logic        frame_err;
    logic        busy;
    logic [15:0] frame_cnt;
    logic [7:0]  err_cnt;

    dac_spi_rx dut (
        .clk_in    (clk_in),
        .rst       (rst),
        .sclk_in   (sclk_in),
        .sync_in   (sync_in),
        .din_in    (din_in),
        .rx_word   (rx_word),
        .rx_code   (rx_code),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .busy      (busy),
        .frame_cnt (frame_cnt),
        .err_cnt   (err_cnt)
    );

    always #10 clk_in = ~clk_in;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_q[$];
    int          valid_seen = 0;
    int          err_seen = 0;
    int          exp_valid = 0;
    int          exp_errp = 0;
    int          stat_good = 0;
    int          stat_err = 0;
    logic [15:0] exp_word = 16'h0000;
    logic        prev_valid = 1'b0;
    logic        prev_err = 1'b0;
    logic [15:0] popped;

`ifdef DAC_SPI_RX_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk_in) begin
        if (rx_valid) begin
            valid_seen++;
            chk("valid_single", {31'd0, prev_valid}, 32'd0);
            chk("sb_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                popped = exp_q.pop_front();
                chk("rx_word", {16'd0, rx_word}, {16'd0, popped});
                chk("rx_code", {24'd0, rx_code}, {24'd0, popped[7:0]});
            end
        end
        if (frame_err) begin
            err_seen++;
            chk("err_single", {31'd0, prev_err}, 32'd0);
        end
        if (rx_valid || frame_err) begin
            chk("valid_err_excl", {31'd0, rx_valid & frame_err}, 32'd0);
        end
        prev_valid = rx_valid;
        prev_err   = frame_err;
    end

    task automatic send_frame(input logic [15:0] word, input int nbits);
        logic [15:0] sh;
        @(negedge clk_in);
        #5;
        sh      = word;
        sync_in = 1'b0;
        din_in  = sh[15];
        #100;
        for (int i = 0; i < nbits; i++) begin
            sclk_in = 1'b1;
            #50;
            sclk_in = 1'b0;
            if (i == 3) chk("busy_mid", {31'd0, busy}, 32'd1);
            sh     = sh << 1;
            din_in = sh[15];
            #50;
        end
        sync_in = 1'b1;
    endtask

    task automatic check_state(input string tag);
        logic [31:0] efc;
        logic [31:0] eec;
        efc = STATS ? (stat_good % 65536) : 0;
        eec = STATS ? ((stat_err > 255) ? 255 : stat_err) : 0;
        chk({tag, "_word"}, {16'd0, rx_word}, {16'd0, exp_word});
        chk({tag, "_valids"}, valid_seen, exp_valid);
        chk({tag, "_errs"}, err_seen, exp_errp);
        chk({tag, "_frame_cnt"}, {16'd0, frame_cnt}, efc);
        chk({tag, "_err_cnt"}, {24'd0, err_cnt}, eec);
        chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] sh;
        repeat (5) @(negedge clk_in);
        chk("rst_word", {16'd0, rx_word}, 32'd0);
        chk("rst_valid", {31'd0, rx_valid}, 32'd0);
        chk("rst_err", {31'd0, frame_err}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
        chk("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
        rst = 1'b1;
        repeat (5) @(negedge clk_in);

        // good frame
        exp_q.push_back(16'h00A5);
        exp_word = 16'h00A5; exp_valid++; stat_good++;
        send_frame(16'h00A5, 16);
        #400;
        check_state("good");

        // short frame: rx_word must hold 0x00A5
        exp_errp++; stat_err++;
        send_frame(16'hBEEF, 10);
        #400;
        check_state("short");

        // overrun frame: valid after bit 16, error at sync rise
        exp_q.push_back(16'h00FF);
        exp_word = 16'h00FF; exp_valid++; stat_good++; exp_errp++; stat_err++;
        send_frame(16'h00FF, 20);
        #400;
        check_state("overrun");

        // back-to-back frames with a one-sclk gap
        exp_q.push_back(16'h0012);
        exp_q.push_back(16'h0034);
        exp_q.push_back(16'h0056);
        exp_word = 16'h0056; exp_valid += 3; stat_good += 3;
        send_frame(16'h0012, 16);
        #100;
        send_frame(16'h0034, 16);
        #100;
        send_frame(16'h0056, 16);
        #400;
        check_state("b2b");

        // reset asserted mid-frame and released while sync is still low
        @(negedge clk_in);
        #5;
        sh      = 16'hFFFF;
        sync_in = 1'b0;
        din_in  = sh[15];
        #100;
        for (int i = 0; i < 16; i++) begin
            sclk_in = 1'b1;
            #50;
            sclk_in = 1'b0;
            sh      = sh << 1;
            din_in  = sh[15];
            if (i == 4) rst = 1'b0;
            if (i == 8) rst = 1'b1;
            if (i == 11) chk("busy_after_rst", {31'd0, busy}, 32'd0);
            #50;
        end
        sync_in = 1'b1;
        #400;
        exp_word = 16'h0000; stat_good = 0; stat_err = 0;
        check_state("rst_mid");

        exp_q.push_back(16'h0077);
        exp_word = 16'h0077; exp_valid++; stat_good++;
        send_frame(16'h0077, 16);
        #400;
        check_state("post_rst");

        chk("sb_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
